// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder with sequential binary-to-BCD conversion and 7-segment drive.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 2,
  parameter int DIGITS  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES:0]     sum,
  output logic [4*DIGITS-1:0]    bcd,
  output logic [7*DIGITS-1:0]    seg
);
  localparam int W  = 4*NIBBLES;
  localparam int CW = $clog2(W+2);
  localparam longint unsigned DEC_RANGE = 64'd10 ** DIGITS;
  localparam longint unsigned BIN_RANGE = 64'd1 << (W+1);

  generate
    if (DEC_RANGE <= BIN_RANGE) begin : g_bad_digits
      $error("DIGITS too small for 4*NIBBLES+1 bit sum");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_CONV = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0011000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  function automatic logic [7*DIGITS-1:0] seg_all(input logic [4*DIGITS-1:0] v);
    logic [7*DIGITS-1:0] r;
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    r = '0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      r[7*i +: 7] = seg7(v[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (v[4*i +: 4] != 4'd0) lead = 1'b0;
      if (lead && i > 0) r[7*i +: 7] = 7'b1111111;
`endif
    end
    return r;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic [W-1:0]        a_q, a_d, b_q, b_d;
  logic [W:0]          wsum_q, wsum_d;
  logic [4*DIGITS-1:0] work_q, work_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [W:0]          sum_q, sum_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;

  logic [W-1:0]        a_sh, b_sh;
  logic [3:0]          g, p, s;
  logic [4:0]          c;
  logic [4*DIGITS-1:0] adj;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    wsum_d  = wsum_q;
    work_d  = work_q;
    sum_d   = sum_q;
    bcd_d   = bcd_q;
    seg_d   = seg_q;

    a_sh = a_q >> {cnt_q, 2'b00};
    b_sh = b_q >> {cnt_q, 2'b00};
    g    = a_sh[3:0] & b_sh[3:0];
    p    = a_sh[3:0] ^ b_sh[3:0];
    c[0] = carry_q;
    for (int j = 0; j < 4; j++) begin
      c[j+1] = g[j] | (p[j] & c[j]);
      s[j]   = p[j] ^ c[j];
    end

    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = (work_q[4*i +: 4] >= 4'd5) ? work_q[4*i +: 4] + 4'd3 : work_q[4*i +: 4];

    case (state_q)
      S_IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        carry_d = cin;
        cnt_d   = '0;
        wsum_d  = '0;
        state_d = S_ADD;
      end
      S_ADD: begin
        wsum_d  = wsum_q | ({{(W-3){1'b0}}, s} << {cnt_q, 2'b00});
        carry_d = c[4];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NIBBLES-1)) begin
          wsum_d[W] = c[4];
          cnt_d     = '0;
          work_d    = '0;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        // Rotating (not shifting) the sum leaves it intact after W+1 steps.
        work_d = {adj[4*DIGITS-2:0], wsum_q[W]};
        wsum_d = {wsum_q[W-1:0], wsum_q[W]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(W)) begin
          sum_d   = wsum_d;
          bcd_d   = work_d;
          seg_d   = seg_all(work_d);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      wsum_q  <= '0;
      work_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      bcd_q   <= '0;
      seg_q   <= seg_all('0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wsum_q  <= wsum_d;
      work_q  <= work_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      bcd_q   <= bcd_d;
      seg_q   <= seg_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign bcd  = bcd_q;
  assign seg  = seg_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed + random bench for nibble_serial_add_ctrl (NIBBLES=2, DIGITS=3) with an arithmetic reference model.
module tb_nibble_serial_add_ctrl;
  localparam int NIBBLES = 2;
  localparam int DIGITS  = 3;
  localparam int W       = 4*NIBBLES;
  localparam int LAT     = 5*NIBBLES+2;
  localparam int PERIOD  = 5*NIBBLES+3;
  localparam logic [6:0] SEGT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done;
  logic [W:0] sum;
  logic [4*DIGITS-1:0] bcd;
  logic [7*DIGITS-1:0] seg;

  int checks = 0, passed = 0;

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES), .DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .bcd(bcd), .seg(seg));

  always #5 clk = ~clk;

  function automatic logic [4*DIGITS-1:0] m_bcd(input int v);
    logic [4*DIGITS-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [7*DIGITS-1:0] m_seg(input int v);
    logic [7*DIGITS-1:0] r = '0;
    int p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[7*i +: 7] = SEGT[(v / p) % 10];
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && v < p) r[7*i +: 7] = 7'b1111111;
`endif
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input int v);
    chk({tag, ".sum"}, 64'(sum), 64'(v));
    chk({tag, ".bcd"}, 64'(bcd), 64'(m_bcd(v)));
    chk({tag, ".seg"}, 64'(seg), 64'(m_seg(v)));
  endtask

  // One operation: start pulse, scramble operands after acceptance, measure latency, check result.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    int cyc, v;
    v = int'(ta) + int'(tb_) + int'(tc);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    cyc = 1;
    chk({tag, ".busy1"}, 64'(busy), 64'd1);
    while (!done && cyc < 4*LAT) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'(LAT));
    chk_result(tag, v);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 64'(done), 64'd0);
    chk({tag, ".idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int v, cyc, prev, ndone;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk_result("rst", 0);

    run_op("max", 8'hFF, 8'hFF, 1'b1);
    chk("max.seg_lit", 64'(seg), 64'({7'b0010010, 7'b1111001, 7'b1111001}));
    run_op("carry", 8'h0F, 8'h01, 1'b0);
    chk("carry.bcd_lit", 64'(bcd), 64'h016);
    run_op("zero", 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++)
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom));

    // start during CONV must be ignored
    a = 8'd50; b = 8'd60; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 8'd7; b = 8'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 6; ndone = 0;
    while (!done && cyc < 4*LAT) begin @(negedge clk); cyc++; end
    chk("ign.latency", 64'(cyc), 64'(LAT));
    chk_result("ign", 110);
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ign.no_second_done", 64'(ndone), 64'd0);

    // reset in ADD cycle 2
    a = 8'd33; b = 8'd44; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst.busy", 64'(busy), 64'd0);
    chk("mrst.done", 64'(done), 64'd0);
    chk_result("mrst", 0);
    run_op("after_rst", 8'd100, 8'd23, 1'b0);
    chk("after_rst.bcd_lit", 64'(bcd), 64'h123);

    // start held high
    a = 8'd9; b = 8'd1; cin = 1'b0; start = 1'b1;
    prev = -1; ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk_result("held", 10);
        if (prev >= 0) chk("held.period", 64'(c - prev), 64'(PERIOD));
        prev = c;
      end
    end
    start = 1'b0;
    chk("held.count", 64'(ndone), 64'd3);
    cyc = 0;
    while (busy && cyc < 4*LAT) begin @(negedge clk); cyc++; end
    chk("held.drain", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
